// File: rtl/matrix_mult_2x2_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_mult_2x2_if
// Brief    : Handshake and operand/result bundle for the 2x2 matrix multiplier.
// Revision : 1.0  initial release
// ============================================================================
interface matrix_mult_2x2_if #(
    parameter int WIDTH = 16
);
    logic                          clk_en;
    logic                          startMul;
    logic [1:0][1:0][WIDTH-1:0]    A;
    logic [1:0][1:0][WIDTH-1:0]    B;
    logic [1:0][1:0][WIDTH-1:0]    Res;
    logic                          endMul;
    logic                          busy;
    logic                          ovf;

    modport master (
        output clk_en, startMul, A, B,
        input  Res, endMul, busy, ovf
    );

    modport slave (
        input  clk_en, startMul, A, B,
        output Res, endMul, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/matrix_mult_2x2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_mult_2x2
// Brief    : Sequential signed fixed-point 2x2 product Res = A*B, one MAC/cycle.
// Revision : 1.0  initial release
// ============================================================================
module matrix_mult_2x2 #(
    parameter int WIDTH     = 16,
    parameter int intDigits = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_mult_2x2_if.slave        bus
);
    localparam int FRAC = WIDTH - intDigits;
    localparam int AW   = 2 * WIDTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [AW-1:0] SAT_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef logic [1:0][1:0][WIDTH-1:0] mat_t;

    logic [1:0]              state_q, state_d;
    logic [2:0]              k_q;
    logic signed [AW-1:0]    acc_q;
    mat_t                    a_q, b_q, buf_q, res_q;
    logic                    flag_q, ovf_q;

    logic                    w_i, w_j, w_m;
    logic signed [WIDTH-1:0] w_a, w_b;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [AW-1:0]    w_sum, w_shift;
    logic [WIDTH-1:0]        w_elem;
    logic                    w_sat;
    mat_t                    w_buf_next;

    // k enumerates (row, col, inner index) with the inner index fastest.
    assign w_i = k_q[2];
    assign w_j = k_q[1];
    assign w_m = k_q[0];

    assign w_a     = a_q[w_i][w_m];
    assign w_b     = b_q[w_m][w_j];
    assign w_prod  = w_a * w_b;
    assign w_sum   = acc_q + $signed({w_prod[2*WIDTH-1], w_prod});
    assign w_shift = w_sum >>> FRAC;

    always_comb begin
        w_sat  = 1'b0;
        w_elem = w_shift[WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_elem = {1'b0, {(WIDTH-1){1'b1}}};
            w_sat  = 1'b1;
        end else if (w_shift < SAT_MIN) begin
            w_elem = {1'b1, {(WIDTH-1){1'b0}}};
            w_sat  = 1'b1;
        end
    end

    always_comb begin
        w_buf_next           = buf_q;
        w_buf_next[w_i][w_j] = w_elem;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.startMul) state_d = MAC;
            MAC:     if (k_q == 3'd7)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            buf_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.clk_en) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.startMul) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        k_q    <= '0;
                        acc_q  <= '0;
                        flag_q <= 1'b0;
                    end
                end
                MAC: begin
                    k_q <= k_q + 3'd1;
                    if (w_m) begin
                        buf_q  <= w_buf_next;
                        acc_q  <= '0;
                        flag_q <= flag_q | w_sat;
                    end else begin
                        acc_q  <= w_sum;
                    end
                    // Last element goes straight to Res so the result appears with DONE.
                    if (k_q == 3'd7) begin
                        res_q <= w_buf_next;
                        ovf_q <= flag_q | w_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Res    = res_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.endMul = (state_q == DONE);
endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_2x2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mult_2x2
// Brief    : Self-checking bench: vector table, random ops vs. arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_mult_2x2;
    localparam int W = 16;
    typedef logic [1:0][1:0][W-1:0] mat_t;
    typedef struct {
        mat_t a;
        mat_t b;
        mat_t res;
        logic ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_mult_2x2_if #(.WIDTH(W)) bus ();
    matrix_mult_2x2 #(.WIDTH(W), .intDigits(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mat_t mk(input logic [15:0] a00, a01, a10, a11);
        mat_t m;
        m[0][0] = a00; m[0][1] = a01; m[1][0] = a10; m[1][1] = a11;
        return m;
    endfunction

    // Reference: exact integer sum, floor division by 64, clamp to 16-bit signed.
    function automatic void model(input mat_t a, input mat_t b, output mat_t r, output logic o);
        longint s;
        o = 1'b0;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = longint'($signed(a[i][0])) * longint'($signed(b[0][j]))
                  + longint'($signed(a[i][1])) * longint'($signed(b[1][j]));
                s = s >>> 6;
                if (s > 32767) begin
                    r[i][j] = 16'h7FFF; o = 1'b1;
                end else if (s < -32768) begin
                    r[i][j] = 16'h8000; o = 1'b1;
                end else begin
                    r[i][j] = s[15:0];
                end
            end
        end
    endfunction

    task automatic run_op(input mat_t a, input mat_t b, input bit stall,
                          output mat_t res, output logic o, output int edges);
        int guard;
        bit en;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.startMul = 1'b1; bus.clk_en = 1'b1;
        @(negedge clk);
        bus.startMul = 1'b0;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        edges = 1;
        guard = 0;
        while (!bus.endMul && guard < 200) begin
            en = stall ? (guard % 2 == 1) : 1'b1;
            bus.clk_en = en;
            @(negedge clk);
            if (en) edges++;
            guard++;
        end
        check("endMul_seen", {63'd0, bus.endMul}, 64'd1);
        res = bus.Res;
        o   = bus.ovf;
        if (stall) begin
            bus.clk_en = 1'b0;
            @(negedge clk);
            check("endMul_held_stalled", {63'd0, bus.endMul}, 64'd1);
        end
        bus.clk_en = 1'b1;
        @(negedge clk);
        check("endMul_one_cycle", {63'd0, bus.endMul}, 64'd0);
    endtask

    initial begin
        mat_t r, er, a, b;
        logic o, eo;
        int e, pulses;

        tbl[0].a = mk(16'h0040, 16'h0000, 16'h0000, 16'h0040);
        tbl[0].b = mk(16'h0060, 16'hFFC0, 16'h0020, 16'h0100);
        tbl[0].res = mk(16'h0060, 16'hFFC0, 16'h0020, 16'h0100); tbl[0].ovf = 1'b0;
        tbl[1].a = mk(16'h0080, 16'h0000, 16'h0000, 16'h0080);
        tbl[1].b = mk(16'hFFE0, 16'hFFE0, 16'hFFE0, 16'hFFE0);
        tbl[1].res = mk(16'hFFC0, 16'hFFC0, 16'hFFC0, 16'hFFC0); tbl[1].ovf = 1'b0;
        tbl[2].a = mk(16'h0040, 16'h0040, 16'h0040, 16'h0040);
        tbl[2].b = mk(16'h0020, 16'h0020, 16'h0020, 16'h0020);
        tbl[2].res = mk(16'h0040, 16'h0040, 16'h0040, 16'h0040); tbl[2].ovf = 1'b0;
        tbl[3].a = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        tbl[3].b = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        tbl[3].res = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000); tbl[3].ovf = 1'b0;
        tbl[4].a = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        tbl[4].b = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        tbl[4].res = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000); tbl[4].ovf = 1'b0;
        tbl[5].a = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        tbl[5].b = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        tbl[5].res = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF); tbl[5].ovf = 1'b1;
        tbl[6].a = mk(16'hC000, 16'h4000, 16'h4000, 16'h4000);
        tbl[6].b = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        tbl[6].res = mk(16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF); tbl[6].ovf = 1'b1;
        tbl[7] = tbl[0];

        rst = 1'b1;
        bus.clk_en = 1'b0; bus.startMul = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        check("reset_res",    bus.Res, 64'd0);
        check("reset_busy",   {63'd0, bus.busy}, 64'd0);
        check("reset_endMul", {63'd0, bus.endMul}, 64'd0);
        check("reset_ovf",    {63'd0, bus.ovf}, 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 8; n++) begin
            run_op(tbl[n].a, tbl[n].b, 1'b0, r, o, e);
            check($sformatf("vec%0d_res", n), r, tbl[n].res);
            check($sformatf("vec%0d_ovf", n), {63'd0, o}, {63'd0, tbl[n].ovf});
            check($sformatf("vec%0d_latency", n), 64'(e), 64'd9);
        end

        run_op(tbl[0].a, tbl[0].b, 1'b1, r, o, e);
        check("stall_res", r, tbl[0].res);
        check("stall_latency", 64'(e), 64'd9);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    a[i][j] = (n % 3 == 0) ? 16'($urandom()) : 16'(int'($urandom_range(0, 511)) - 256);
                    b[i][j] = (n % 3 == 0) ? 16'($urandom()) : 16'(int'($urandom_range(0, 511)) - 256);
                end
            end
            model(a, b, er, eo);
            run_op(a, b, (n % 4 == 3), r, o, e);
            check($sformatf("rand%0d_res", n), r, er);
            check($sformatf("rand%0d_ovf", n), {63'd0, o}, {63'd0, eo});
        end

        // Start pulse while busy plus operand change after acceptance.
        @(negedge clk);
        bus.A = tbl[1].a; bus.B = tbl[1].b; bus.startMul = 1'b1; bus.clk_en = 1'b1;
        @(negedge clk);
        bus.startMul = 1'b0;
        bus.A = mk(16'h7FFF, 16'h1234, 16'h8000, 16'h0100);
        bus.B = mk(16'h0040, 16'h0040, 16'h0040, 16'h0040);
        repeat (3) @(negedge clk);
        bus.startMul = 1'b1;
        @(negedge clk);
        bus.startMul = 1'b0;
        pulses = 0;
        r = '0;
        for (int c = 0; c < 25; c++) begin
            if (bus.endMul) begin
                pulses++;
                r = bus.Res;
            end
            @(negedge clk);
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_res", r, tbl[1].res);

        // Abort at k=4.
        @(negedge clk);
        bus.A = tbl[0].a; bus.B = tbl[0].b; bus.startMul = 1'b1;
        @(negedge clk);
        bus.startMul = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_res",  bus.Res, 64'd0);
        check("abort_endMul", {63'd0, bus.endMul}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.endMul) pulses++;
            @(negedge clk);
        end
        check("abort_no_end", 64'(pulses), 64'd0);
        run_op(tbl[2].a, tbl[2].b, 1'b0, r, o, e);
        check("after_abort_res", r, tbl[2].res);
        check("after_abort_latency", 64'(e), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
